// File: rtl/blowfish_pkg.sv
// -----------------------------------------------------------------------------
// blowfish_pkg
// Shared constants and types for the Blowfish S-box writer.
//   SBOX_DEPTH  : number of S-box entries (256)
//   SBOX_WORD   : S-box entry width in bits (32)
//   PAIR_COUNT  : key-schedule pairs needed to refill one S-box (128)
//   SBOX_AW     : S-box address width
//   PAIR_AW     : pair counter width
//   sbox_state_t: writer control states
// -----------------------------------------------------------------------------
package blowfish_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int SBOX_WORD  = 32;
    localparam int PAIR_COUNT = 128;
    localparam int SBOX_AW    = $clog2(SBOX_DEPTH);
    localparam int PAIR_AW    = $clog2(PAIR_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_READY
    } sbox_state_t;

endpackage

// File: rtl/sbox_ram.sv
// -----------------------------------------------------------------------------
// sbox_ram
// 256x32 synchronous memory, one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old word.
// Optional feature macro: SBOX_WRITER_PARITY_EN stores an even-parity bit per
// entry and flags a read word whose parity does not check.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (read register only)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : registered read data (one-cycle latency)
//   parity_err : registered parity failure flag (SBOX_WRITER_PARITY_EN only)
// -----------------------------------------------------------------------------
module sbox_ram
    import blowfish_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [SBOX_AW-1:0]   waddr,
    input  logic [SBOX_WORD-1:0] wdata,
    input  logic [SBOX_AW-1:0]   raddr,
    output logic [SBOX_WORD-1:0] rdata
`ifdef SBOX_WRITER_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

`ifdef SBOX_WRITER_PARITY_EN
    localparam int ENTRY_W = SBOX_WORD + 1;
`else
    localparam int ENTRY_W = SBOX_WORD;
`endif

    logic [ENTRY_W-1:0] mem [SBOX_DEPTH];
    logic [ENTRY_W-1:0] wentry;

`ifdef SBOX_WRITER_PARITY_EN
    // Stored bit makes the total number of ones in the entry even.
    assign wentry = {^wdata, wdata};
`else
    assign wentry = wdata;
`endif

    // NOTE: the storage array has no reset; contents survive rst so a
    // partially written table stays visible, and the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    // NOTE: non-blocking assignments here mean the read samples the array
    // before this edge's write lands, which gives read-old-on-collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
`ifdef SBOX_WRITER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rdata <= mem[raddr][SBOX_WORD-1:0];
`ifdef SBOX_WRITER_PARITY_EN
            parity_err <= ^mem[raddr];
`endif
        end
    end

endmodule

// File: rtl/sbox_writer.sv
// -----------------------------------------------------------------------------
// sbox_writer
// Fills a Blowfish S-box: first copies a constant table from an external
// combinational ROM (INIT), then overwrites it with 128 key-schedule pairs
// (LOAD), each pair written as two consecutive entries. Lookups run in every
// state with one-cycle latency.
// Optional feature macro: SBOX_WRITER_PARITY_EN adds per-entry parity and the
// parity_err output.
// Parameters:
//   INIT_ON_RESET : 1 = start the table copy in the first cycle after rst
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   init_start : one-cycle pulse, (re)start the table copy
//   rom_addr   : constant-table index, 0 outside INIT
//   rom_data   : constant-table word for rom_addr, same cycle
//   wr_valid   : key-schedule pair valid
//   wr_ready   : pair accepted when wr_valid && wr_ready
//   wr_data    : pair {L[63:32], R[31:0]}
//   rd_addr    : lookup index
//   rd_data    : lookup result, registered
//   busy       : high in INIT or LOAD
//   done       : one-cycle pulse when the last pair has been written
//   parity_err : lookup word failed parity (SBOX_WRITER_PARITY_EN only)
// -----------------------------------------------------------------------------
module sbox_writer
    import blowfish_pkg::*;
#(
    parameter int INIT_ON_RESET = 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_start,
    output logic [SBOX_AW-1:0]     rom_addr,
    input  logic [SBOX_WORD-1:0]   rom_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [2*SBOX_WORD-1:0] wr_data,
    input  logic [SBOX_AW-1:0]     rd_addr,
    output logic [SBOX_WORD-1:0]   rd_data,
    output logic                   busy,
    output logic                   done
`ifdef SBOX_WRITER_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam logic [SBOX_AW-1:0] LAST_IDX  = SBOX_AW'(SBOX_DEPTH - 1);
    localparam logic [PAIR_AW-1:0] LAST_PAIR = PAIR_AW'(PAIR_COUNT - 1);

    sbox_state_t          state;
    logic [PAIR_AW-1:0]   pair_idx;
    logic                 second_half;   // R word of the accepted pair still pending
    logic [SBOX_WORD-1:0] r_hold;
    logic                 auto_start;    // first cycle after rst, when enabled

    logic                 we;
    logic [SBOX_AW-1:0]   waddr;
    logic [SBOX_WORD-1:0] wdata;
    logic                 handshake;

    assign handshake = wr_valid && wr_ready;

    // Control FSM; rom_addr doubles as the INIT index so it is 0 elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            pair_idx    <= '0;
            second_half <= 1'b0;
            r_hold      <= '0;
            wr_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            auto_start  <= (INIT_ON_RESET != 0);
        end else begin
            done       <= 1'b0;
            auto_start <= 1'b0;
            if (init_start || (state == ST_IDLE && auto_start)) begin
                state       <= ST_INIT;
                rom_addr    <= '0;
                pair_idx    <= '0;
                second_half <= 1'b0;
                wr_ready    <= 1'b0;
                busy        <= 1'b1;
            end else begin
                case (state)
                    ST_INIT: begin
                        if (rom_addr == LAST_IDX) begin
                            state    <= ST_LOAD;
                            rom_addr <= '0;
                            wr_ready <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (second_half) begin
                            second_half <= 1'b0;
                            if (pair_idx == LAST_PAIR) begin
                                state <= ST_READY;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                pair_idx <= pair_idx + 1'b1;
                                wr_ready <= 1'b1;
                            end
                        end else if (handshake) begin
                            r_hold      <= wr_data[SBOX_WORD-1:0];
                            second_half <= 1'b1;
                            wr_ready    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write-port steering. Writes are suppressed on rst and init_start so an
    // abort never lands a stray entry.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst && !init_start) begin
            case (state)
                ST_INIT: begin
                    we    = 1'b1;
                    waddr = rom_addr;
                    wdata = rom_data;
                end
                ST_LOAD: begin
                    if (second_half) begin
                        we    = 1'b1;
                        waddr = {pair_idx, 1'b1};
                        wdata = r_hold;
                    end else if (handshake) begin
                        we    = 1'b1;
                        waddr = {pair_idx, 1'b0};
                        wdata = wr_data[2*SBOX_WORD-1:SBOX_WORD];
                    end
                end
                default: ;
            endcase
        end
    end

    sbox_ram u_ram (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (rd_addr),
        .rdata      (rd_data)
`ifdef SBOX_WRITER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

endmodule

// File: tb/tb_sbox_writer.sv
// -----------------------------------------------------------------------------
// tb_sbox_writer
// Self-checking bench for sbox_writer. A reference array tracks what every
// S-box entry should hold; random lookups are compared against it each cycle,
// alongside directed checks of the control outputs.
// -----------------------------------------------------------------------------
module tb_sbox_writer;

    logic        clk;
    logic        rst;
    logic        init_start;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
`ifdef SBOX_WRITER_PARITY_EN
    logic        parity_err;
`endif

    sbox_writer dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
`ifdef SBOX_WRITER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'(a) * 32'h01010101;
    endfunction

    // Value left by the full A/B load in entry a.
    function automatic logic [31:0] pairval(input int a);
        return (a % 2 == 1) ? 32'hB0000000 + 32'(a / 2) : 32'hA0000000 + 32'(a / 2);
    endfunction

    assign rom_data = rom(rom_addr);

    int vectors;
    int miscompares;
    int done_cnt;

    logic [31:0] model [256];
    bit          known [256];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predicts the lookup from the reference array as it stands
    // before the edge, then applies the write the edge is expected to make.
    task automatic step(input bit w, input int wa, input logic [31:0] wd);
        logic [31:0] exp;
        bit          kn;
        bit          in_rst;
        exp    = model[rd_addr];
        kn     = known[rd_addr];
        in_rst = rst;
        @(posedge clk);
        #1;
        if (w) begin
            model[wa] = wd;
            known[wa] = 1'b1;
        end
        if (in_rst) begin
            check("rd_rst", rd_data, 0);
        end else if (kn) begin
            check("rd_data", rd_data, exp);
`ifdef SBOX_WRITER_PARITY_EN
            check("parity", parity_err, 0);
`endif
        end
        rd_addr = 8'($urandom);
    endtask

    task automatic run_init(input int first, input int last);
        for (int i = first; i < last; i++) begin
            check("rom_addr", rom_addr, i);
            check("init_ready", wr_ready, 0);
            check("init_busy", busy, 1);
            step(1'b1, i, rom(8'(i)));
        end
    endtask

    task automatic load_pairs(input int first_k, input int last_k,
                              input logic [31:0] lbase, input logic [31:0] rbase,
                              input bit no_gap_first);
        int n;
        for (int k = first_k; k <= last_k; k++) begin
            if (!(no_gap_first && k == first_k)) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step(1'b0, 0, 0);
            end
            wr_valid = 1'b1;
            wr_data  = {lbase + 32'(k), rbase + 32'(k)};
            n = 0;
            while (wr_ready !== 1'b1 && n < 8) begin
                step(1'b0, 0, 0);
                n++;
            end
            if (n == 8) begin
                check("hs_timeout", wr_ready, 1);
                return;
            end
            if (k == 1) rd_addr = 8'd2;
            step(1'b1, 2 * k, lbase + 32'(k));
            if (k == 1) check("coll_old", rd_data, rom(8'd2));
            wr_valid = 1'b0;
            wr_data  = {$urandom, $urandom};
            check("ready_drop", wr_ready, 0);
            if (k == 1) rd_addr = 8'd2;
            step(1'b1, 2 * k + 1, rbase + 32'(k));
            if (k == 1) check("coll_new", rd_data, lbase + 32'd1);
            if (k == 127) begin
                check("done_pulse", done, 1);
                check("ready_end", wr_ready, 0);
                check("busy_end", busy, 0);
            end else begin
                check("ready_back", wr_ready, 1);
                check("no_done", done, 0);
            end
        end
    endtask

    initial begin
        int base_done;
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        rst        = 1'b1;
        init_start = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_addr    = '0;

        // Reset values.
        repeat (3) step(1'b0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", wr_ready, 0);
        check("rst_done", done, 0);
        check("rst_rom_addr", rom_addr, 0);

        // Auto INIT after reset, with a pair already waiting on wr_valid.
        wr_valid = 1'b1;
        wr_data  = {32'hA0000000, 32'hB0000000};
        rst      = 1'b0;
        step(1'b0, 0, 0);
        check("auto_busy", busy, 1);
        run_init(0, 255);
        check("rom_addr_last", rom_addr, 255);
        rd_addr = 8'h05;
        step(1'b1, 255, rom(8'd255));
        check("rd_05", rd_data, 32'h05050505);
        check("load_ready", wr_ready, 1);
        check("load_rom_addr", rom_addr, 0);

        // Partial random load, then abort at pair 40.
        load_pairs(0, 39, $urandom, $urandom, 1'b1);
        wr_valid = 1'b0;
        step(1'b0, 0, 0);
        init_start = 1'b1;
        step(1'b0, 0, 0);
        init_start = 1'b0;
        check("abort_rom_addr", rom_addr, 0);
        check("abort_busy", busy, 1);
        check("abort_ready", wr_ready, 0);
        check("abort_no_done", done_cnt, 0);
        run_init(0, 256);

        // Full load of 128 pairs.
        base_done = done_cnt;
        load_pairs(0, 127, 32'hA0000000, 32'hB0000000, 1'b0);
        rd_addr = 8'h00;
        step(1'b0, 0, 0);
        check("done_once", done, 0);
        check("entry0_new", rd_data, 32'hA0000000);

        // READY ignores wr_valid.
        wr_valid = 1'b1;
        wr_data  = {$urandom, $urandom};
        repeat (5) begin
            step(1'b0, 0, 0);
            check("ready_hold", wr_ready, 0);
        end
        wr_valid = 1'b0;
        check("done_count", done_cnt - base_done, 1);

        // Sweep the whole table.
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            step(1'b0, 0, 0);
            check("sweep", rd_data, pairval(a));
        end

        // Fresh INIT from READY, reset at index 100.
        init_start = 1'b1;
        step(1'b0, 0, 0);
        init_start = 1'b0;
        check("reinit_busy", busy, 1);
        run_init(0, 100);
        check("rom_addr_100", rom_addr, 100);
        rst = 1'b1;
        step(1'b0, 0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", wr_ready, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        rst = 1'b0;
        step(1'b0, 0, 0);
        check("auto_busy2", busy, 1);
        // Entries 100..255 must still hold load values; read each just ahead
        // of the new INIT index.
        for (int j = 0; j < 156; j++) begin
            check("rom_addr2", rom_addr, j);
            rd_addr = 8'(100 + j);
            step(1'b1, j, rom(8'(j)));
            check("keep_hi", rd_data, pairval(100 + j));
        end
        run_init(156, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
